// File: rtl/i2c_target.sv
// I2C-style target: oversampled SCL/SDA, 7-bit address + RNW, one 16-bit word per transfer.
// SDA is only ever pulled low; SDA_OE selects between driving 0 and releasing the line.
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h2A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        SCL,
   input  logic        SDA_IN,
   output logic        SDA_OE,
   output logic        SDA_OUT,
   input  logic [15:0] RD_DATA,
   output logic [15:0] WR_DATA,
   output logic        WR_STB,
   output logic        BUSY
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_BYTE,
      WR_ACK,
      RD_BYTE,
      RD_ACK,
      WAIT_STOP
   } state_t;

   // Synchronizers and edge-detect copies run free of reset so that pin levels
   // are already settled when reset releases and no phantom events appear.
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;

   logic scl_s, sda_s;
   logic scl_rise, scl_fall, start_det, stop_det;

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic        byte_idx_q, byte_idx_d;
   logic        rnw_q, rnw_d;
   logic        ack_ok_q, ack_ok_d;
   logic [7:0]  addr_sh_q, addr_sh_d;
   logic [15:0] wr_sh_q, wr_sh_d;
   logic [15:0] rd_sh_q, rd_sh_d;
   logic        sda_oe_q, sda_oe_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        wr_stb_q, wr_stb_d;
   logic        busy_q, busy_d;

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA_IN};
      scl_prev_d = scl_sync_q[SYNC_STAGES-1];
      sda_prev_d = sda_sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge CLK) begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_idx_d = byte_idx_q;
      rnw_d      = rnw_q;
      ack_ok_d   = ack_ok_q;
      addr_sh_d  = addr_sh_q;
      wr_sh_d    = wr_sh_q;
      rd_sh_d    = rd_sh_q;
      sda_oe_d   = sda_oe_q;
      wr_data_d  = wr_data_q;
      wr_stb_d   = 1'b0;
      busy_d     = busy_q;

      if (start_det) begin
         state_d    = ADDR;
         bit_cnt_d  = 4'd0;
         byte_idx_d = 1'b0;
         sda_oe_d   = 1'b0;
         busy_d     = 1'b1;
      end else if (stop_det) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;

            ADDR: begin
               if (scl_rise) begin
                  addr_sh_d = {addr_sh_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = 4'd0;
                  if (addr_sh_q[7:1] == TARGET_ADDR) begin
                     sda_oe_d = 1'b1;
                     rnw_d    = addr_sh_q[0];
                     rd_sh_d  = RD_DATA;
                     state_d  = ADDR_ACK;
                  end else begin
                     state_d = WAIT_STOP;
                  end
               end
            end

            ADDR_ACK: begin
               if (scl_fall) begin
                  byte_idx_d = 1'b0;
                  if (rnw_q) begin
                     sda_oe_d  = ~rd_sh_q[15];
                     rd_sh_d   = {rd_sh_q[14:0], 1'b0};
                     bit_cnt_d = 4'd1;
                     state_d   = RD_BYTE;
                  end else begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     state_d   = WR_BYTE;
                  end
               end
            end

            WR_BYTE: begin
               if (scl_rise) begin
                  wr_sh_d   = {wr_sh_q[14:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  sda_oe_d  = 1'b1;
                  bit_cnt_d = 4'd0;
                  state_d   = WR_ACK;
               end
            end

            WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  if (!byte_idx_q) begin
                     byte_idx_d = 1'b1;
                     state_d    = WR_BYTE;
                  end else begin
                     wr_data_d = wr_sh_q;
                     wr_stb_d  = 1'b1;
                     state_d   = WAIT_STOP;
                  end
               end
            end

            // bit_cnt counts bits already presented on the line
            RD_BYTE: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     state_d   = RD_ACK;
                  end else begin
                     sda_oe_d  = ~rd_sh_q[15];
                     rd_sh_d   = {rd_sh_q[14:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end

            RD_ACK: begin
               if (scl_rise) begin
                  ack_ok_d = ~sda_s;
               end else if (scl_fall) begin
                  if (ack_ok_q && !byte_idx_q) begin
                     sda_oe_d   = ~rd_sh_q[15];
                     rd_sh_d    = {rd_sh_q[14:0], 1'b0};
                     bit_cnt_d  = 4'd1;
                     byte_idx_d = 1'b1;
                     state_d    = RD_BYTE;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = WAIT_STOP;
                  end
               end
            end

            WAIT_STOP: sda_oe_d = 1'b0;

            default: begin
               state_d  = IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 4'd0;
         byte_idx_q <= 1'b0;
         rnw_q      <= 1'b0;
         ack_ok_q   <= 1'b0;
         addr_sh_q  <= 8'd0;
         wr_sh_q    <= 16'd0;
         rd_sh_q    <= 16'd0;
         sda_oe_q   <= 1'b0;
         wr_data_q  <= 16'd0;
         wr_stb_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_idx_q <= byte_idx_d;
         rnw_q      <= rnw_d;
         ack_ok_q   <= ack_ok_d;
         addr_sh_q  <= addr_sh_d;
         wr_sh_q    <= wr_sh_d;
         rd_sh_q    <= rd_sh_d;
         sda_oe_q   <= sda_oe_d;
         wr_data_q  <= wr_data_d;
         wr_stb_q   <= wr_stb_d;
         busy_q     <= busy_d;
      end
   end

   assign SDA_OE  = sda_oe_q;
   assign SDA_OUT = 1'b0;
   assign WR_DATA = wr_data_q;
   assign WR_STB  = wr_stb_q;
   assign BUSY    = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged initiator on a wired-AND SDA, scoreboard queues
// of expected ACKs, read bytes and write words.
module tb_i2c_target;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        scl_m;
   logic        sda_m;
   logic        sda_line;
   logic        SDA_OE;
   logic        SDA_OUT;
   logic [15:0] RD_DATA;
   logic [15:0] WR_DATA;
   logic        WR_STB;
   logic        BUSY;

   int checks = 0;
   int passed = 0;
   int stb_cnt = 0;

   bit         ack_q[$];
   bit [7:0]   byte_q[$];
   bit [15:0]  word_q[$];

   assign sda_line = sda_m & (SDA_OE ? SDA_OUT : 1'b1);

   i2c_target #(.TARGET_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .SCL     (scl_m),
      .SDA_IN  (sda_line),
      .SDA_OE  (SDA_OE),
      .SDA_OUT (SDA_OUT),
      .RD_DATA (RD_DATA),
      .WR_DATA (WR_DATA),
      .WR_STB  (WR_STB),
      .BUSY    (BUSY)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (WR_STB === 1'b1) stb_cnt++;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic bus_start();
      wait_clk(3); sda_m = 1'b1;
      wait_clk(3); scl_m = 1'b1;
      wait_clk(6); sda_m = 1'b0;
      wait_clk(6); scl_m = 1'b0;
   endtask

   task automatic bus_stop();
      wait_clk(3); sda_m = 1'b0;
      wait_clk(3); scl_m = 1'b1;
      wait_clk(6); sda_m = 1'b1;
      wait_clk(6);
   endtask

   // One SCL clock; samples the resolved line and SDA_OE in the middle of SCL high.
   task automatic bus_bit(input logic b, output logic line, output logic oe);
      wait_clk(3); sda_m = b;
      wait_clk(3); scl_m = 1'b1;
      wait_clk(5); line = sda_line; oe = SDA_OE;
      wait_clk(1); scl_m = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack_oe, output logic data_oe);
      logic line, oe;
      data_oe = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(b[i], line, oe);
         data_oe = data_oe | oe;
      end
      bus_bit(1'b1, line, oe);
      ack_oe = oe;
   endtask

   task automatic recv_byte(input logic ack, output logic [7:0] v, output logic ack_oe);
      logic line, oe;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, line, oe);
         v[i] = line;
      end
      bus_bit(ack, line, oe);
      ack_oe = oe;
   endtask

   task automatic test_reset();
      RESET = 1'b1; scl_m = 1'b1; sda_m = 1'b1; RD_DATA = 16'h0000;
      wait_clk(8);
      RESET = 1'b0;
      wait_clk(2);
      checks++; if ({SDA_OE, SDA_OUT, WR_STB, BUSY} !== 4'b0000) $display("FAIL reset_ctl: got %b required 0000", {SDA_OE, SDA_OUT, WR_STB, BUSY}); else passed++;
      checks++; if (WR_DATA !== 16'h0000) $display("FAIL reset_wr_data: got %h required 0000", WR_DATA); else passed++;
   endtask

   task automatic test_write();
      logic a, d, any_d;
      int base;
      bit [15:0] ew;
      logic [7:0] bytes [2];
      bytes[0] = 8'hBE; bytes[1] = 8'hEF;
      base = stb_cnt;
      bus_start();
      checks++; if (BUSY !== 1'b1) $display("FAIL wr_busy_start: got %b required 1", BUSY); else passed++;
      word_q.push_back(16'hBEEF);
      ack_q.push_back(1'b1);
      send_byte(8'h54, a, any_d);
      checks++; if (a !== ack_q.pop_front()) $display("FAIL wr_addr_ack: got %b required 1", a); else passed++;
      for (int k = 0; k < 2; k++) begin
         ack_q.push_back(1'b1);
         send_byte(bytes[k], a, d);
         any_d = any_d | d;
         checks++; if (a !== ack_q.pop_front()) $display("FAIL wr_data_ack%0d: got %b required 1", k, a); else passed++;
      end
      checks++; if (any_d !== 1'b0) $display("FAIL wr_no_drive_data: got %b required 0", any_d); else passed++;
      wait_clk(4);
      ew = word_q.pop_front();
      checks++; if (WR_DATA !== ew) $display("FAIL wr_data: got %h required %h", WR_DATA, ew); else passed++;
      checks++; if (stb_cnt - base !== 1) $display("FAIL wr_stb_width: got %0d required 1", stb_cnt - base); else passed++;
      bus_stop();
      checks++; if (BUSY !== 1'b0) $display("FAIL wr_busy_stop: got %b required 0", BUSY); else passed++;
   endtask

   task automatic test_read();
      logic a, d;
      logic [7:0] v;
      bit [7:0] eb;
      RD_DATA = 16'hA55A;
      bus_start();
      send_byte(8'h55, a, d);
      checks++; if (a !== 1'b1) $display("FAIL rd_addr_ack: got %b required 1", a); else passed++;
      byte_q.push_back(8'hA5); byte_q.push_back(8'h5A);
      RD_DATA = 16'h0000;
      recv_byte(1'b0, v, a);
      eb = byte_q.pop_front();
      checks++; if (v !== eb) $display("FAIL rd_byte1: got %h required %h", v, eb); else passed++;
      checks++; if (a !== 1'b0) $display("FAIL rd_ack1_released: got %b required 0", a); else passed++;
      recv_byte(1'b1, v, a);
      eb = byte_q.pop_front();
      checks++; if (v !== eb) $display("FAIL rd_byte2: got %h required %h", v, eb); else passed++;
      checks++; if (a !== 1'b0) $display("FAIL rd_ack2_released: got %b required 0", a); else passed++;
      bus_stop();
      checks++; if (BUSY !== 1'b0) $display("FAIL rd_busy_stop: got %b required 0", BUSY); else passed++;
   endtask

   task automatic test_nomatch();
      logic a, d, any_oe;
      int base;
      base = stb_cnt;
      bus_start();
      send_byte(8'h56, a, d);
      any_oe = a | d;
      send_byte(8'h11, a, d);
      any_oe = any_oe | a | d;
      send_byte(8'h22, a, d);
      any_oe = any_oe | a | d;
      checks++; if (any_oe !== 1'b0) $display("FAIL nm_no_drive: got %b required 0", any_oe); else passed++;
      checks++; if (BUSY !== 1'b1) $display("FAIL nm_busy: got %b required 1", BUSY); else passed++;
      bus_stop();
      checks++; if (stb_cnt - base !== 0) $display("FAIL nm_stb: got %0d required 0", stb_cnt - base); else passed++;
      checks++; if (WR_DATA !== 16'hBEEF) $display("FAIL nm_wr_data: got %h required beef", WR_DATA); else passed++;
      checks++; if (BUSY !== 1'b0) $display("FAIL nm_busy_stop: got %b required 0", BUSY); else passed++;
   endtask

   task automatic test_partial();
      logic a, d;
      int base;
      base = stb_cnt;
      bus_start();
      send_byte(8'h54, a, d);
      send_byte(8'h12, a, d);
      checks++; if (a !== 1'b1) $display("FAIL part_ack: got %b required 1", a); else passed++;
      bus_stop();
      checks++; if (WR_DATA !== 16'hBEEF) $display("FAIL part_wr_data: got %h required beef", WR_DATA); else passed++;
      checks++; if (stb_cnt - base !== 0) $display("FAIL part_stb: got %0d required 0", stb_cnt - base); else passed++;
      checks++; if ({BUSY, SDA_OE} !== 2'b00) $display("FAIL part_idle: got %b required 00", {BUSY, SDA_OE}); else passed++;
   endtask

   task automatic test_restart();
      logic a, d;
      logic [7:0] v;
      int base;
      base = stb_cnt;
      RD_DATA = 16'h0FF0;
      bus_start();
      send_byte(8'h54, a, d);
      send_byte(8'h34, a, d);
      bus_start();
      checks++; if (BUSY !== 1'b1) $display("FAIL rs_busy: got %b required 1", BUSY); else passed++;
      send_byte(8'h55, a, d);
      checks++; if (a !== 1'b1) $display("FAIL rs_addr_ack: got %b required 1", a); else passed++;
      byte_q.push_back(8'h0F); byte_q.push_back(8'hF0);
      recv_byte(1'b0, v, a);
      checks++; if (v !== byte_q.pop_front()) $display("FAIL rs_byte1: got %h required 0f", v); else passed++;
      recv_byte(1'b1, v, a);
      checks++; if (v !== byte_q.pop_front()) $display("FAIL rs_byte2: got %h required f0", v); else passed++;
      bus_stop();
      checks++; if (WR_DATA !== 16'hBEEF) $display("FAIL rs_wr_data: got %h required beef", WR_DATA); else passed++;
      checks++; if (stb_cnt - base !== 0) $display("FAIL rs_stb: got %0d required 0", stb_cnt - base); else passed++;
   endtask

   task automatic test_reset_mid_read();
      logic a, d;
      logic [7:0] v;
      RD_DATA = 16'h00FF;
      bus_start();
      send_byte(8'h55, a, d);
      wait_clk(6);
      checks++; if (SDA_OE !== 1'b1) $display("FAIL rr_driving0: got %b required 1", SDA_OE); else passed++;
      RESET = 1'b1;
      wait_clk(1);
      checks++; if ({SDA_OE, BUSY} !== 2'b00) $display("FAIL rr_after_reset: got %b required 00", {SDA_OE, BUSY}); else passed++;
      checks++; if (WR_DATA !== 16'h0000) $display("FAIL rr_wr_data: got %h required 0000", WR_DATA); else passed++;
      RESET = 1'b0;
      RD_DATA = 16'hC33C;
      bus_start();
      send_byte(8'h55, a, d);
      checks++; if (a !== 1'b1) $display("FAIL rr_addr_ack: got %b required 1", a); else passed++;
      byte_q.push_back(8'hC3); byte_q.push_back(8'h3C);
      recv_byte(1'b0, v, a);
      checks++; if (v !== byte_q.pop_front()) $display("FAIL rr_byte1: got %h required c3", v); else passed++;
      recv_byte(1'b1, v, a);
      checks++; if (v !== byte_q.pop_front()) $display("FAIL rr_byte2: got %h required 3c", v); else passed++;
      bus_stop();
   endtask

   task automatic test_back_to_back();
      logic a, d;
      int base;
      bit [15:0] words [2];
      bit [15:0] ew;
      words[0] = 16'h1357; words[1] = 16'h2468;
      for (int k = 0; k < 2; k++) begin
         base = stb_cnt;
         word_q.push_back(words[k]);
         bus_start();
         send_byte(8'h54, a, d);
         send_byte(words[k][15:8], a, d);
         send_byte(words[k][7:0], a, d);
         send_byte(8'h99, a, d);
         checks++; if (a !== 1'b0) $display("FAIL b2b_extra_nack%0d: got %b required 0", k, a); else passed++;
         bus_stop();
         ew = word_q.pop_front();
         checks++; if (WR_DATA !== ew) $display("FAIL b2b_word%0d: got %h required %h", k, WR_DATA, ew); else passed++;
         checks++; if (stb_cnt - base !== 1) $display("FAIL b2b_stb%0d: got %0d required 1", k, stb_cnt - base); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_nomatch();
      test_partial();
      test_restart();
      test_reset_mid_read();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
